huffman_decoder: RTL and testbench
==================================

# huffman_decoder

Receive-side counterpart of the `huffman` encoder. It loads the six-symbol code table (`HC1..HC6`, `M1..M6`) when the encoder pulses `code_valid`. It then consumes a serial codeword bitstream, one bit per accepted cycle, and emits the decoded symbol index 1..6. It sits downstream of the encoder, both for round-trip checking and as the decode path of the image pipeline.

## Interface
Parameters:
- None. The symbol count (6) and code width (8) are fixed by the encoder's port format.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `code_valid` in 1: one-cycle pulse. Captures `HC1..HC6` and `M1..M6` into the internal table.
- `HC1..HC6` in 8 each: codeword bits, right-aligned.
- `M1..M6` in 8 each: length masks, thermometer coded from bit 0. Length L gives `M = 2^L-1`. `M = 0` marks the symbol unused.
- `bit_valid` in 1: qualifies `bit_in`.
- `bit_in` in 1: next code bit, MSB of the codeword first (bit L-1 down to bit 0).
- `table_ready` out 1: table loaded, decoder accepting bits.
- `sym_valid` out 1: one-cycle pulse, symbol decoded.
- `sym` out 3: decoded symbol, 1..6. Held until the next `sym_valid`.
- `err` out 1: one-cycle pulse. No table entry matched within 8 bits.

## Operation
- States:
  - EMPTY: after reset; bits ignored.
  - RUN: decoding.
- EMPTY→RUN on `code_valid`. RUN stays RUN; `code_valid` in RUN reloads the table.
- Table load:
  - Register all 12 bytes.
  - Clear the accumulator `acc[7:0]` and the length mask `len[7:0]` to 0.
- Bit acceptance in RUN with `bit_valid=1`:
  - `acc_n = {acc[6:0], bit_in}`.
  - `len_n = {len[6:0], 1'b1}`.
- Match test, on `acc_n`/`len_n`:
  - Symbol i matches when `M_i != 0`, `len_n == M_i`, and `acc_n == (HC_i & M_i)`.
  - On a match at any length, the lowest i wins.
- On match:
  - Register `sym=i`; pulse `sym_valid`.
  - Clear `acc` and `len`.
- No match and `len_n == 8'hFF`:
  - Pulse `err`; clear `acc` and `len`.
  - `sym` is unchanged.
- Otherwise: keep `acc_n` and `len_n`.
- Simultaneous `code_valid` and `bit_valid`: the table load wins, the bit is dropped, and the accumulator is cleared.
- `sym_valid` and `err` never assert together.
- Reset mid-codeword: returns to EMPTY, the partial codeword is discarded, and the table is cleared to 0.

## Timing
- Reset values (registered outputs):
  - `table_ready=0`, `sym_valid=0`, `sym=3'd0`, `err=0`.
  - Table, `acc`, `len` all 0.
- `table_ready` rises the cycle after the `code_valid` edge.
- A bit with `bit_valid` high on the edge where `table_ready=1` is accepted.
- Latency: `sym_valid`/`err` is high during the cycle after the edge accepting the final bit.
- Throughput:
  - One bit per cycle, with no back-pressure.
  - 1-bit codes can yield a symbol every cycle.
  - `bit_valid` may gap arbitrarily; the state holds.

## Configuration
- `HUFFMAN_DEC_CNT_EN` defined:
  - Adds outputs `DCNT1..DCNT6` (8 bits each), counting decoded occurrences of each symbol.
  - The counts are comparable against the encoder's `CNT1..CNT6`.
  - Counters reset to 0 on `reset` and on a table load.
  - They increment with `sym_valid`, saturating at 255. `err` does not count.
- Not defined: no counters and no `DCNT` ports. All other behaviour is identical.

## Test plan
Table T used below:
- 1=`0` (`HC1=00`, `M1=01`)
- 2=`10` (`HC2=02`, `M2=03`)
- 3=`110` (`HC3=06`, `M3=07`)
- 4=`1110` (`HC4=0E`, `M4=0F`)
- 5=`11110` (`HC5=1E`, `M5=1F`)
- 6=`11111` (`HC6=1F`, `M6=1F`)

Scenarios:
1. Reset mid-stream, then toggle bits without a table → all outputs 0, `table_ready=0`, no `sym_valid`.
2. Load T, stream bits 0,1,0,1,1,1,1,1 back-to-back → `sym_valid` pulses the cycle after bits 1, 3 and 8, with `sym` = 1, 2, 6.
3. Load T with `M6=00`, stream eight 1s → no `sym_valid`; `err` pulses once, the cycle after the 8th bit. Next bit 0 decodes `sym=1`.
4. Load T, send 1,1, then `code_valid` together with `bit_valid`, then bit 0 → partial flushed, simultaneous bit dropped, `sym=1`.
5. Load T, send `1110` with 0–3 idle cycles between bits → a single `sym_valid` with `sym=4`.
6. With `HUFFMAN_DEC_CNT_EN`, load T, decode symbols 3,3,1,5 → `DCNT1=1`, `DCNT3=2`, `DCNT5=1`, others 0. 260 decodes of symbol 1 → `DCNT1=255`.

Source files
------------

// File: rtl/huffman_decoder.sv
// Six-symbol serial Huffman decoder; HUFFMAN_DEC_CNT_EN adds per-symbol decode counters DCNT1..DCNT6.
// Latency: sym_valid/err is high the cycle after the edge accepting the final code bit.
// Backpressure: none, one bit per cycle; bit_valid may gap freely and state holds.
module huffman_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       table_ready,
    output logic       sym_valid,
    output logic [2:0] sym,
    output logic       err
`ifdef HUFFMAN_DEC_CNT_EN
    ,
    output logic [7:0] DCNT1,
    output logic [7:0] DCNT2,
    output logic [7:0] DCNT3,
    output logic [7:0] DCNT4,
    output logic [7:0] DCNT5,
    output logic [7:0] DCNT6
`endif
);

    typedef enum logic {EMPTY, RUN} state_t;

    state_t          state_q, state_d;
    logic [5:0][7:0] hc_q, m_q;
    logic [5:0][7:0] hc_in, m_in;
    logic [7:0]      acc_q, acc_d, len_q, len_d;
    logic [7:0]      acc_n, len_n;
    logic [2:0]      sym_d;
    logic            sym_valid_d, err_d;
    logic            load;
    logic            hit;
    logic [2:0]      hit_idx;

    assign hc_in = {HC6, HC5, HC4, HC3, HC2, HC1};
    assign m_in  = {M6, M5, M4, M3, M2, M1};

    assign acc_n = {acc_q[6:0], bit_in};
    assign len_n = {len_q[6:0], 1'b1};

    // Scan downwards so the lowest matching symbol index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m_q[i] != 8'd0 && len_n == m_q[i] && acc_n == (hc_q[i] & m_q[i])) begin
                hit     = 1'b1;
                hit_idx = 3'(i + 1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        len_d       = len_q;
        sym_d       = sym;
        sym_valid_d = 1'b0;
        err_d       = 1'b0;
        load        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (code_valid) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (code_valid) begin
                    load = 1'b1;
                end else if (bit_valid) begin
                    if (hit) begin
                        sym_d       = hit_idx;
                        sym_valid_d = 1'b1;
                        acc_d       = 8'd0;
                        len_d       = 8'd0;
                    end else if (len_n == 8'hFF) begin
                        err_d = 1'b1;
                        acc_d = 8'd0;
                        len_d = 8'd0;
                    end else begin
                        acc_d = acc_n;
                        len_d = len_n;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        // A table load always flushes any partial codeword.
        if (load) begin
            acc_d = 8'd0;
            len_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            hc_q      <= '0;
            m_q       <= '0;
            acc_q     <= 8'd0;
            len_q     <= 8'd0;
            sym       <= 3'd0;
            sym_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            len_q     <= len_d;
            sym       <= sym_d;
            sym_valid <= sym_valid_d;
            err       <= err_d;
            if (load) begin
                hc_q <= hc_in;
                m_q  <= m_in;
            end
        end
    end

    assign table_ready = (state_q == RUN);

`ifdef HUFFMAN_DEC_CNT_EN
    logic [5:0][7:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sym_valid_d && sym_d == 3'(i + 1) && cnt_q[i] != 8'hFF)
                    cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end

    assign DCNT1 = cnt_q[0];
    assign DCNT2 = cnt_q[1];
    assign DCNT3 = cnt_q[2];
    assign DCNT4 = cnt_q[3];
    assign DCNT5 = cnt_q[4];
    assign DCNT6 = cnt_q[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: a per-cycle vector table plus hand sequences for reset and counters.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_valid;
    logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0] M1, M2, M3, M4, M5, M6;
    logic       bit_valid;
    logic       bit_in;
    logic       table_ready;
    logic       sym_valid;
    logic [2:0] sym;
    logic       err;
`ifdef HUFFMAN_DEC_CNT_EN
    logic [7:0] DCNT1, DCNT2, DCNT3, DCNT4, DCNT5, DCNT6;
`endif

    huffman_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (HC1),
        .HC2        (HC2),
        .HC3        (HC3),
        .HC4        (HC4),
        .HC5        (HC5),
        .HC6        (HC6),
        .M1         (M1),
        .M2         (M2),
        .M3         (M3),
        .M4         (M4),
        .M5         (M5),
        .M6         (M6),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .table_ready(table_ready),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .err        (err)
`ifdef HUFFMAN_DEC_CNT_EN
        ,
        .DCNT1      (DCNT1),
        .DCNT2      (DCNT2),
        .DCNT3      (DCNT3),
        .DCNT4      (DCNT4),
        .DCNT5      (DCNT5),
        .DCNT6      (DCNT6)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [7:0] m6;
        logic       bv;
        logic       b;
        logic       rdy;
        logic       sv;
        logic [2:0] sym;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle before sampling.
    task automatic step(input logic cv, input logic bv, input logic b);
        @(negedge clk);
        code_valid = cv;
        bit_valid  = bv;
        bit_in     = b;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        bit_valid  = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic sv,
                              input logic [2:0] s, input logic e);
        check({tag, ".table_ready"}, int'(table_ready), int'(rdy));
        check({tag, ".sym_valid"},   int'(sym_valid),   int'(sv));
        check({tag, ".sym"},         int'(sym),         int'(s));
        check({tag, ".err"},         int'(err),         int'(e));
    endtask

    task automatic add(input logic cv, input logic [7:0] m6, input logic bv, input logic b,
                       input logic rdy, input logic sv, input logic [2:0] s, input logic e);
        vec_t v;
        v.cv = cv; v.m6 = m6; v.bv = bv; v.b = b;
        v.rdy = rdy; v.sv = sv; v.sym = s; v.err = e;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        HC1 = 8'h00; HC2 = 8'h02; HC3 = 8'h06; HC4 = 8'h0E; HC5 = 8'h1E; HC6 = 8'h1F;
        M1  = 8'h01; M2  = 8'h03; M3  = 8'h07; M4  = 8'h0F; M5  = 8'h1F; M6  = 8'h1F;

        // Vector table: cv, M6, bit_valid, bit_in -> table_ready, sym_valid, sym, err
        add(1, 8'h1F, 0, 0, 1, 0, 0, 0);                  // load T
        add(0, 8'h1F, 1, 0, 1, 1, 1, 0);                  // 0 -> 1
        add(0, 8'h1F, 1, 1, 1, 0, 1, 0);
        add(0, 8'h1F, 1, 0, 1, 1, 2, 0);                  // 10 -> 2
        for (int k = 0; k < 4; k++) add(0, 8'h1F, 1, 1, 1, 0, 2, 0);
        add(0, 8'h1F, 1, 1, 1, 1, 6, 0);                  // 11111 -> 6
        add(1, 8'h00, 0, 0, 1, 0, 6, 0);                  // load T with symbol 6 unused
        for (int k = 0; k < 7; k++) add(0, 8'h00, 1, 1, 1, 0, 6, 0);
        add(0, 8'h00, 1, 1, 1, 0, 6, 1);                  // 8th one: err, sym held
        add(0, 8'h00, 1, 0, 1, 1, 1, 0);
        add(1, 8'h1F, 0, 0, 1, 0, 1, 0);                  // reload T
        add(0, 8'h1F, 1, 1, 1, 0, 1, 0);
        add(0, 8'h1F, 1, 1, 1, 0, 1, 0);
        add(1, 8'h1F, 1, 1, 1, 0, 1, 0);                  // load beats the bit
        add(0, 8'h1F, 1, 0, 1, 1, 1, 0);
        add(0, 8'h1F, 1, 1, 1, 0, 1, 0);                  // 1110 with gaps
        add(0, 8'h1F, 0, 1, 1, 0, 1, 0);
        add(0, 8'h1F, 1, 1, 1, 0, 1, 0);
        add(0, 8'h1F, 0, 1, 1, 0, 1, 0);
        add(0, 8'h1F, 0, 1, 1, 0, 1, 0);
        add(0, 8'h1F, 1, 1, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 8'h1F, 0, 0, 1, 0, 1, 0);
        add(0, 8'h1F, 1, 0, 1, 1, 4, 0);
        add(0, 8'h1F, 1, 0, 1, 1, 1, 0);                  // back-to-back 1-bit codes
        add(0, 8'h1F, 1, 0, 1, 1, 1, 0);

        // Reset state and a reset mid-codeword
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0);
        reset = 1'b0;
        step(1, 0, 0);
        check("s1.load_rdy", int'(table_ready), 1);
        step(0, 1, 0);
        check("s1.first_sym", int'(sym), 1);
        step(0, 1, 1);
        step(0, 1, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("s1.async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, k[0]);
            check_outs($sformatf("s1.no_table%0d", k), 0, 0, 0, 0);
        end

        foreach (vecs[i]) begin
            M6 = vecs[i].m6;
            step(vecs[i].cv, vecs[i].bv, vecs[i].b);
            check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].sv, vecs[i].sym, vecs[i].err);
        end

`ifdef HUFFMAN_DEC_CNT_EN
        M6 = 8'h1F;
        step(1, 0, 0);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
        check("cnt.d1", int'(DCNT1), 1);
        check("cnt.d2", int'(DCNT2), 0);
        check("cnt.d3", int'(DCNT3), 2);
        check("cnt.d4", int'(DCNT4), 0);
        check("cnt.d5", int'(DCNT5), 1);
        check("cnt.d6", int'(DCNT6), 0);
        for (int k = 0; k < 260; k++) step(0, 1, 0);
        check("cnt.sat1", int'(DCNT1), 255);
        check("cnt.keep3", int'(DCNT3), 2);
        step(1, 0, 0);
        check("cnt.load_clr", int'(DCNT1), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
